// File: rtl/rxcommaalignen_gpo_ctrl_pkg.sv
// Shared types and constants for the GPO-driven comma-align controller.
package rxcommaalignen_gpo_ctrl_pkg;

  localparam int unsigned GPIO_W      = 16;
  localparam int unsigned GPIO_OFFSET = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } align_state_e;

endpackage

// File: rtl/comma_align_ch_fsm.sv
// Per-channel comma-align sequencer: request edge -> align window -> lock or timeout.
module comma_align_ch_fsm
  import rxcommaalignen_gpo_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic sync_vld,
  input  logic req_s,
  input  logic aligned_s,
  output logic align_en,
  output logic locked,
  output logic timed_out
);

  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned CYC_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  align_state_e      state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              req_prev_q, req_prev_d;
  logic              align_en_q, align_en_d;
  logic              locked_q, locked_d;
  logic              timed_out_q, timed_out_d;
  logic              rise_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      lock_q      <= '0;
      req_prev_q  <= 1'b0;
      align_en_q  <= 1'b0;
      locked_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      lock_q      <= lock_d;
      req_prev_q  <= req_prev_d;
      align_en_q  <= align_en_d;
      locked_q    <= locked_d;
      timed_out_q <= timed_out_d;
    end
  end

  // History reads as 1 until the synchronizer has flushed, so a request
  // already high out of reset must drop before it can start alignment.
  always_comb begin
    state_d    = state_q;
    cyc_d      = '0;
    lock_d     = '0;
    req_prev_d = sync_vld ? req_s : 1'b1;
    rise_c     = req_s & ~req_prev_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        cyc_d = (cyc_q == CYC_LAST) ? cyc_q : cyc_q + CYC_W'(1);
        if (!aligned_s)            lock_d = '0;
        else if (lock_q == LOCK_MAX) lock_d = lock_q;
        else                       lock_d = lock_q + LOCK_W'(1);
        if (!req_s)                 state_d = ST_IDLE;
        else if (lock_d == LOCK_MAX) state_d = ST_LOCKED;
        else if (cyc_q == CYC_LAST) state_d = ST_TIMEOUT;
      end
      ST_LOCKED: begin
        if (!req_s)          state_d = ST_IDLE;
        else if (!aligned_s) state_d = ST_ALIGN;
      end
      ST_TIMEOUT: begin
        if (!req_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    align_en_d  = 1'b0;
    locked_d    = 1'b0;
    timed_out_d = 1'b0;
    unique case (state_q)
      ST_ALIGN:   align_en_d  = 1'b1;
      ST_LOCKED:  locked_d    = 1'b1;
      ST_TIMEOUT: timed_out_d = 1'b1;
      default:    ;
    endcase
  end

  assign align_en  = align_en_q;
  assign locked    = locked_q;
  assign timed_out = timed_out_q;

endmodule

// File: rtl/rxcommaalignen_gpo_ctrl.sv
// Two-channel GT comma-align enable control from a software GPO word, status on GPI.
module rxcommaalignen_gpo_ctrl
  import rxcommaalignen_gpo_ctrl_pkg::*;
#(
  parameter int unsigned CHANNEL_ID     = 2,
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [GPIO_W-1:0] gpo_in,
  input  logic              rxbyteisaligned_ch2,
  input  logic              rxbyteisaligned_ch3,
  output logic              rxcommaalignen_out_ch2,
  output logic              rxcommaalignen_out_ch3,
  output logic [GPIO_W-1:0] gpi_out
);

  localparam int unsigned REQ_LSB = CHANNEL_ID + GPIO_OFFSET;
  localparam logic [GPIO_W-1:0] REQ_MASK = GPIO_W'(3) << REQ_LSB;

  logic [1:0] req_meta_q, req_meta_d;
  logic [1:0] req_sync_q, req_sync_d;
  logic [1:0] algn_meta_q, algn_meta_d;
  logic [1:0] algn_sync_q, algn_sync_d;
  logic [1:0] vld_q, vld_d;
  logic [1:0] en_c, lock_c, tmo_c;
  logic       unused_gpo;

  // Only the two channel request bits are consumed; the rest of the word is ignored.
  assign unused_gpo = ^(gpo_in & ~REQ_MASK);

  always_comb begin
    req_meta_d  = {gpo_in[REQ_LSB+1], gpo_in[REQ_LSB]};
    req_sync_d  = req_meta_q;
    algn_meta_d = {rxbyteisaligned_ch3, rxbyteisaligned_ch2};
    algn_sync_d = algn_meta_q;
    vld_d       = {vld_q[0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_meta_q  <= '0;
      req_sync_q  <= '0;
      algn_meta_q <= '0;
      algn_sync_q <= '0;
      vld_q       <= '0;
    end else begin
      req_meta_q  <= req_meta_d;
      req_sync_q  <= req_sync_d;
      algn_meta_q <= algn_meta_d;
      algn_sync_q <= algn_sync_d;
      vld_q       <= vld_d;
    end
  end

  comma_align_ch_fsm #(
    .LOCK_CYCLES   (LOCK_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm_ch2 (
    .clk      (clk),
    .resetn   (resetn),
    .sync_vld (vld_q[1]),
    .req_s    (req_sync_q[0]),
    .aligned_s(algn_sync_q[0]),
    .align_en (en_c[0]),
    .locked   (lock_c[0]),
    .timed_out(tmo_c[0])
  );

  comma_align_ch_fsm #(
    .LOCK_CYCLES   (LOCK_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm_ch3 (
    .clk      (clk),
    .resetn   (resetn),
    .sync_vld (vld_q[1]),
    .req_s    (req_sync_q[1]),
    .aligned_s(algn_sync_q[1]),
    .align_en (en_c[1]),
    .locked   (lock_c[1]),
    .timed_out(tmo_c[1])
  );

  assign rxcommaalignen_out_ch2 = en_c[0];
  assign rxcommaalignen_out_ch3 = en_c[1];

  always_comb begin
    gpi_out               = '0;
    gpi_out[REQ_LSB]      = lock_c[0];
    gpi_out[REQ_LSB+1]    = lock_c[1];
    gpi_out[CHANNEL_ID]   = tmo_c[0];
    gpi_out[CHANNEL_ID+1] = tmo_c[1];
  end

endmodule

// File: tb/tb_rxcommaalignen_gpo_ctrl.sv
// Bench for rxcommaalignen_gpo_ctrl: directed scenarios plus random traffic against a history-based model.
module tb_rxcommaalignen_gpo_ctrl;

  localparam int unsigned CH   = 2;
  localparam int unsigned LOCK = 16;
  localparam int unsigned TMO  = 100;
  localparam logic [15:0] REQ_MASK = 16'h0C00;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] gpo_in;
  logic        al2, al3;
  logic        en2, en3;
  logic [15:0] gpi_out;

  always #5 clk = ~clk;

  rxcommaalignen_gpo_ctrl #(
    .CHANNEL_ID    (CH),
    .LOCK_CYCLES   (LOCK),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .gpo_in                (gpo_in),
    .rxbyteisaligned_ch2   (al2),
    .rxbyteisaligned_ch3   (al3),
    .rxcommaalignen_out_ch2(en2),
    .rxcommaalignen_out_ch3(en3),
    .gpi_out               (gpi_out)
  );

  int errors = 0;
  int checks = 0;
  int en_cnt[2];

  // Model: raw input samples since reset, plus per-channel status flags and edge stamps.
  bit [3:0] raw_q[$];
  bit       m_aligning[2], m_locked[2], m_timedout[2];
  int       m_first[2], m_bad[2];
  bit       exp_en[2], exp_lk[2], exp_to[2];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic go_idle(input int ch);
    m_aligning[ch] = 1'b0;
    m_locked[ch]   = 1'b0;
    m_timedout[ch] = 1'b0;
  endtask

  task automatic start_align(input int ch, input int e);
    go_idle(ch);
    m_aligning[ch] = 1'b1;
    m_first[ch]    = e + 1;
    m_bad[ch]      = e;
  endtask

  // Edge e (1-based after reset) sees raw input from edge e-2 through the synchronizers.
  task automatic model_edge();
    int       e;
    bit [3:0] now;
    bit       sreq, sal, rise;
    if (resetn !== 1'b1) begin
      raw_q.delete();
      for (int ch = 0; ch < 2; ch++) begin
        go_idle(ch);
        exp_en[ch] = 1'b0;
        exp_lk[ch] = 1'b0;
        exp_to[ch] = 1'b0;
      end
      return;
    end
    e   = raw_q.size() + 1;
    now = {al3, al2, gpo_in[CH+9], gpo_in[CH+8]};
    for (int ch = 0; ch < 2; ch++) begin
      exp_en[ch] = m_aligning[ch];
      exp_lk[ch] = m_locked[ch];
      exp_to[ch] = m_timedout[ch];
    end
    for (int ch = 0; ch < 2; ch++) begin
      sreq = 1'b0;
      sal  = 1'b0;
      rise = 1'b0;
      if (e >= 3) begin
        sreq = raw_q[e-3][ch];
        sal  = raw_q[e-3][ch+2];
      end
      if (e >= 4) rise = sreq && !raw_q[e-4][ch];
      if (!(m_aligning[ch] || m_locked[ch] || m_timedout[ch])) begin
        if (rise) start_align(ch, e);
      end else if (!sreq) begin
        go_idle(ch);
      end else if (m_aligning[ch]) begin
        if (!sal) m_bad[ch] = e;
        if (e - m_bad[ch] >= int'(LOCK)) begin
          go_idle(ch);
          m_locked[ch] = 1'b1;
        end else if (e - m_first[ch] + 1 >= int'(TMO)) begin
          go_idle(ch);
          m_timedout[ch] = 1'b1;
        end
      end else if (m_locked[ch] && !sal) begin
        start_align(ch, e);
      end
    end
    raw_q.push_back(now);
  endtask

  task automatic cycle(input int n);
    logic [15:0] exp_gpi;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_edge();
      exp_gpi         = '0;
      exp_gpi[CH+8]   = exp_lk[0];
      exp_gpi[CH+9]   = exp_lk[1];
      exp_gpi[CH]     = exp_to[0];
      exp_gpi[CH+1]   = exp_to[1];
      check_eq("en_ch2", 16'(en2), 16'(exp_en[0]));
      check_eq("en_ch3", 16'(en3), 16'(exp_en[1]));
      check_eq("gpi_out", gpi_out, exp_gpi);
      if (en2 === 1'b1) en_cnt[0]++;
      if (en3 === 1'b1) en_cnt[1]++;
    end
  endtask

  initial begin
    bit r2, r3;
    resetn = 1'b0;
    gpo_in = '0;
    al2    = 1'b0;
    al3    = 1'b0;
    cycle(3);
    resetn = 1'b1;
    cycle(5);

    // ch2 locks once aligned holds for LOCK cycles
    en_cnt = '{0, 0};
    gpo_in = 16'h0400;
    cycle(10);
    al2 = 1'b1;
    cycle(30);
    check_eq("lock_en_cycles", 16'(en_cnt[0]), 16'd25);
    check_eq("lock_gpi", gpi_out, 16'h0400);
    check_eq("lock_ch3_quiet", 16'(en_cnt[1]), 16'd0);

    // one-cycle alignment drop while locked -> realign and relock
    en_cnt = '{0, 0};
    al2 = 1'b0;
    cycle(1);
    al2 = 1'b1;
    cycle(30);
    check_eq("relock_en_cycles", 16'(en_cnt[0]), 16'd16);
    check_eq("relock_gpi", gpi_out, 16'h0400);
    gpo_in = '0;
    al2    = 1'b0;
    cycle(6);
    check_eq("clear_gpi", gpi_out, 16'h0000);

    // ch3 never aligned -> timeout after exactly TMO enable cycles
    en_cnt = '{0, 0};
    gpo_in = 16'h0800;
    cycle(120);
    check_eq("tmo_en_cycles", 16'(en_cnt[1]), 16'(TMO));
    check_eq("tmo_gpi", gpi_out, 16'h0008);
    gpo_in = '0;
    cycle(6);
    check_eq("tmo_clear_gpi", gpi_out, 16'h0000);

    // runs of LOCK-1 aligned cycles never lock
    gpo_in = 16'h0400;
    for (int i = 0; i < 130; i++) begin
      al2 = ((i % 16) < 15);
      cycle(1);
    end
    check_eq("short_runs_gpi", gpi_out, 16'h0004);
    gpo_in = '0;
    al2    = 1'b0;
    cycle(6);

    // reset mid-align with request held: no restart until the request toggles
    gpo_in = 16'h0400;
    cycle(20);
    resetn = 1'b0;
    cycle(1);
    resetn = 1'b1;
    en_cnt = '{0, 0};
    cycle(10);
    check_eq("rst_held_en_cycles", 16'(en_cnt[0]), 16'd0);
    check_eq("rst_held_gpi", gpi_out, 16'h0000);
    gpo_in = '0;
    cycle(3);
    gpo_in = 16'h0400;
    cycle(6);
    check_eq("restart_en", 16'(en2), 16'd1);
    gpo_in = '0;
    cycle(6);

    // both channels: ch2 lock coincides with its timeout cycle, ch3 times out
    en_cnt = '{0, 0};
    gpo_in = 16'h0C00;
    cycle(85);
    al2 = 1'b1;
    cycle(35);
    check_eq("tie_en2_cycles", 16'(en_cnt[0]), 16'(TMO));
    check_eq("tie_en3_cycles", 16'(en_cnt[1]), 16'(TMO));
    check_eq("tie_gpi", gpi_out, 16'h0408);
    gpo_in = '0;
    al2    = 1'b0;
    cycle(6);

    // random traffic with noise on unrelated GPO bits and occasional resets
    r2 = 1'b0;
    r3 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 119) == 0) r2 = ~r2;
      if ($urandom_range(0, 119) == 0) r3 = ~r3;
      if ($urandom_range(0, 14) == 0)  al2 = ~al2;
      if ($urandom_range(0, 24) == 0)  al3 = ~al3;
      gpo_in = (16'($urandom) & ~REQ_MASK) | (16'(r2) << (CH + 8)) | (16'(r3) << (CH + 9));
      resetn = ($urandom_range(0, 599) != 0);
      cycle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
